// File: rtl/sram_burst_ctrl_pkg.sv
// Shared types and constants for the SRAM burst controller (package mem_pkg).
package mem_pkg;

    localparam int unsigned MEM_BURST_LEN = 16;
    localparam int unsigned MEM_ADDR_W    = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ACCESS,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_TAIL
    } mem_state_e;

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Cache-side memory bus: request fields from the cache, ready/return path back.
interface sram_burst_ctrl_if;
    import mem_pkg::*;

    logic [MEM_ADDR_W-1:0] mem_addr;
    logic                  mem_en;
    logic                  mem_wr;
    logic                  mem_rburst;
    logic                  mem_wburst;
    logic [7:0]            mem_wdata;
    logic                  mem_rdy;
    logic [7:0]            mem_rdata;
    logic [7:0]            mem_rdata0;
    logic                  mem_rdata_load;

    modport master (
        output mem_addr, mem_en, mem_wr, mem_rburst, mem_wburst, mem_wdata,
        input  mem_rdy, mem_rdata, mem_rdata0, mem_rdata_load
    );

    modport slave (
        input  mem_addr, mem_en, mem_wr, mem_rburst, mem_wburst, mem_wdata,
        output mem_rdy, mem_rdata, mem_rdata0, mem_rdata_load
    );

endinterface

// File: rtl/sram_burst_ctrl.sv
// Byte-wide asynchronous SRAM controller serving the instruction cache:
// single reads, single writes and wrapping read bursts for line fills.
// Optional build macro SRAM_INPUT_REG_EN registers sram_dq_i before use,
// delaying each read strobe by one cycle and adding a TAIL state.
module sram_burst_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned BURST_LEN   = MEM_BURST_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_burst_ctrl_if.slave      bus,
    output logic [MEM_ADDR_W-1:0] sram_addr,
    output logic [7:0]            sram_dq_o,
    output logic                  sram_dq_oe,
    input  logic [7:0]            sram_dq_i,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    localparam int unsigned     BW        = $clog2(BURST_LEN);
    localparam logic [3:0]      WAIT_LAST = 4'(WAIT_STATES);
    localparam logic [BW-1:0]   BEAT_LAST = BW'(BURST_LEN - 1);

`ifdef SRAM_INPUT_REG_EN
    localparam mem_state_e RD_DONE = ST_TAIL;
`else
    localparam mem_state_e RD_DONE = ST_IDLE;
`endif

    mem_state_e    state_q, state_d;
    logic [3:0]    wait_cnt_q;
    logic [BW-1:0] beat_cnt_q;
    logic          burst_q;
    logic [7:0]    rdata_q;
    logic          rdy;
    logic          wait_end;
    logic          rd_end;
    logic          rd_load;
    logic [7:0]    rd_byte;
    logic          load;
    logic [7:0]    load_byte;
    logic          unused_wburst;

    // Write bursts are not supported; the request bit is deliberately dropped.
    assign unused_wburst = bus.mem_wburst;

    assign wait_end = (wait_cnt_q == WAIT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and SRAM strobe generation
    always_comb begin
        state_d    = state_q;
        rd_end     = 1'b0;
        rdy        = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rdy = 1'b1;
                if (bus.mem_en) state_d = bus.mem_wr ? ST_WR_SETUP : ST_RD_ACCESS;
            end
            ST_RD_ACCESS: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                if (wait_end) begin
                    rd_end = 1'b1;
                    if (!burst_q || beat_cnt_q == BEAT_LAST) state_d = RD_DONE;
                end
            end
            ST_WR_SETUP: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                state_d    = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                sram_we_n  = 1'b0;
                if (wait_end) state_d = ST_WR_HOLD;
            end
            ST_WR_HOLD: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_TAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SRAM_INPUT_REG_EN
    logic [7:0] dq_reg_q;
    logic       load_pend_q;

    // Input capture: the strobe trails the beat end by one cycle, so the
    // next burst beat's access overlaps the previous beat's strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_reg_q    <= '0;
            load_pend_q <= 1'b0;
        end else begin
            dq_reg_q    <= sram_dq_i;
            load_pend_q <= rd_end;
        end
    end

    assign rd_load = load_pend_q;
    assign rd_byte = dq_reg_q;
`else
    assign rd_load = rd_end;
    assign rd_byte = sram_dq_i;
`endif

    // A write completion strobes with the previous byte so the fill stream is untouched
    assign load      = rd_load | (state_q == ST_WR_HOLD);
    assign load_byte = rd_load ? rd_byte : rdata_q;

    assign bus.mem_rdy        = rdy;
    assign bus.mem_rdata      = rdata_q;
    assign bus.mem_rdata0     = load_byte;
    assign bus.mem_rdata_load = load;

    // Request capture, wait/beat counters and burst address stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            beat_cnt_q <= '0;
            burst_q    <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wait_cnt_q <= '0;
                    beat_cnt_q <= '0;
                    if (bus.mem_en) begin
                        sram_addr <= bus.mem_addr;
                        burst_q   <= bus.mem_rburst & ~bus.mem_wr;
                        if (bus.mem_wr) sram_dq_o <= bus.mem_wdata;
                    end
                end
                ST_RD_ACCESS: begin
                    if (wait_end) begin
                        wait_cnt_q <= '0;
                        if (burst_q) begin
                            beat_cnt_q          <= beat_cnt_q + BW'(1);
                            sram_addr[BW-1:0]   <= sram_addr[BW-1:0] + BW'(1);
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                ST_WR_PULSE: begin
                    if (wait_end) wait_cnt_q <= '0;
                    else          wait_cnt_q <= wait_cnt_q + 4'd1;
                end
                default: wait_cnt_q <= '0;
            endcase
            if (load) rdata_q <= load_byte;
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Self-checking bench for sram_burst_ctrl: directed cases pinned by literal
// values, randomized traffic against a transaction-level model, and a
// mid-burst reset. Honours SRAM_INPUT_REG_EN when defined at build time.
module tb_sram_burst_ctrl;
    import mem_pkg::*;

    localparam int W = 1;
    localparam int L = W + 1;
`ifdef SRAM_INPUT_REG_EN
    localparam int X = 1;
`else
    localparam int X = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] sram_addr;
    logic [7:0]  sram_dq_o;
    logic [7:0]  sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    sram_burst_ctrl_if bus();

    sram_burst_ctrl #(.WAIT_STATES(W), .BURST_LEN(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Initial SRAM contents: 0xA5 at 0x234, 0..15 at 0xBC0..0xBCF, a pattern elsewhere
    function automatic logic [7:0] init_byte(input int i);
        logic [11:0] a;
        a = 12'(i);
        if (a == 12'h234) return 8'hA5;
        if (a[11:4] == 8'hBC) return {4'h0, a[3:0]};
        return a[7:0] ^ {a[11:8], 4'h3};
    endfunction

    // Asynchronous SRAM model (4 KiB, address aliased on the low 12 bits)
    logic [7:0] sram_arr [4096];
    bit         sram_ready = 1'b0;
    always @(posedge clk) begin
        if (!sram_ready) begin
            for (int i = 0; i < 4096; i++) sram_arr[i] <= init_byte(i);
            sram_ready <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            sram_arr[sram_addr[11:0]] <= sram_dq_o;
        end
    end
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_arr[sram_addr[11:0]] : 8'hEE;

    // Transaction-level reference model
    logic [7:0] mm [4096];
    bit         exp_load [int];
    logic [7:0] exp_data [int];
    int         busy_from = 1, busy_to = 0, next_idle = 0;
    logic [7:0] last_model = 8'h00;
    logic [7:0] cur_rd = 8'h00;
    logic [7:0] exp_wd = 8'h00;
    bit         chk_en = 1'b0;
    int         checks = 0, passes = 0;

    typedef struct {int c; logic [7:0] d;} obs_t;
    obs_t        obs [$];
    logic [23:0] addr_q [$];
    int          we_cnt = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    function automatic void add_strobe(input int c, input logic [7:0] d);
        exp_load[c] = 1'b1;
        exp_data[c] = d;
        last_model  = d;
    endfunction

    // Expected strobes and busy window for a transaction accepted in cycle t0
    function automatic void model_txn(input int kind, input logic [23:0] a,
                                      input logic [7:0] wd, input int t0);
        int         e;
        logic [3:0] lo;
        e = t0;
        if (kind == 0) begin
            e = t0 + L + X;
            add_strobe(e, mm[a[11:0]]);
        end else if (kind == 1) begin
            for (int k = 1; k <= 16; k++) begin
                lo = a[3:0] + 4'(k - 1);
                e  = t0 + k * L + X;
                add_strobe(e, mm[{a[11:4], lo}]);
            end
        end else begin
            e = t0 + W + 3;
            add_strobe(e, last_model);
            mm[a[11:0]] = wd;
            exp_wd      = wd;
        end
        busy_from = t0 + 1;
        busy_to   = e;
        next_idle = e + 1;
    endfunction

    // Per-cycle comparison against the model
    int         cc;
    bit         eb;
    obs_t       o;
    always @(negedge clk) begin
        if (chk_en) begin
            cc = cyc;
            if (exp_load.exists(cc - 1)) cur_rd = exp_data[cc - 1];
            eb = exp_load.exists(cc);
            chk("rdy", 32'(bus.mem_rdy), 32'(!(cc >= busy_from && cc <= busy_to)));
            chk("load", 32'(bus.mem_rdata_load), 32'(eb));
            if (eb && bus.mem_rdata_load) chk("rdata0", 32'(bus.mem_rdata0), 32'(exp_data[cc]));
            chk("rdata", 32'(bus.mem_rdata), 32'(cur_rd));
            chk("contention", 32'(!sram_oe_n && sram_dq_oe), 32'(0));
            if (!sram_we_n) begin
                we_cnt++;
                chk("wr_bus", {22'h0, sram_dq_oe, sram_ce_n, sram_dq_o}, {22'h0, 1'b1, 1'b0, exp_wd});
            end
            if (bus.mem_rdata_load) begin
                o.c = cc;
                o.d = bus.mem_rdata0;
                obs.push_back(o);
            end
            if (!sram_ce_n && !sram_oe_n && (addr_q.size() == 0 || addr_q[$] != sram_addr))
                addr_q.push_back(sram_addr);
        end
    end

    // Issue one request in an idle cycle and ride it out to the next idle cycle
    task automatic issue(input int kind, input logic [23:0] a, input logic [7:0] wd,
                         input bit hold_en, output int t0);
        t0              = cyc;
        bus.mem_en      = 1'b1;
        bus.mem_wr      = (kind == 2);
        bus.mem_rburst  = (kind == 1) ? 1'b1 : ((kind == 2) ? 1'($urandom) : 1'b0);
        bus.mem_wburst  = 1'($urandom);
        bus.mem_addr    = a;
        bus.mem_wdata   = wd;
        model_txn(kind, a, wd, t0);
        while (cyc < next_idle) begin
            @(negedge clk);
            if (cyc < next_idle) begin
                if (hold_en) begin
                    bus.mem_en = (cyc < busy_to);
                end else begin
                    bus.mem_en     = 1'($urandom);
                    bus.mem_wr     = 1'($urandom);
                    bus.mem_rburst = 1'($urandom);
                    bus.mem_addr   = 24'($urandom);
                    bus.mem_wdata  = 8'($urandom);
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            bus.mem_en     = 1'b0;
            bus.mem_wr     = 1'($urandom);
            bus.mem_rburst = 1'($urandom);
            bus.mem_addr   = 24'($urandom);
            @(negedge clk);
        end
        next_idle = cyc;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0, kind, n;
        logic [23:0] a;

        for (int i = 0; i < 4096; i++) mm[i] = init_byte(i);
        bus.mem_en = 1'b0; bus.mem_wr = 1'b0; bus.mem_rburst = 1'b0;
        bus.mem_wburst = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_rdy",   32'(bus.mem_rdy), 32'(1));
        chk("rst_ce_n",  32'(sram_ce_n), 32'(1));
        chk("rst_oe_n",  32'(sram_oe_n), 32'(1));
        chk("rst_we_n",  32'(sram_we_n), 32'(1));
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'(0));
        chk("rst_load",  32'(bus.mem_rdata_load), 32'(0));
        chk("rst_rdata", 32'(bus.mem_rdata), 32'(0));
        chk("rst_addr",  32'(sram_addr), 32'(0));
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle_cycles(2);

        // Single read: 0xA5 strobed W+1 cycles after accept
        obs.delete();
        issue(0, 24'h001234, 8'h00, 1'b1, t0);
        chk("rd_count", 32'(obs.size()), 32'(1));
        if (obs.size() > 0) begin
            chk("rd_cycle", 32'(obs[0].c - t0), 32'(X ? 3 : 2));
            chk("rd_data", 32'(obs[0].d), 32'(8'hA5));
        end
        chk("rd_rdata_hold", 32'(bus.mem_rdata), 32'(8'hA5));
        idle_cycles(1);

        // Aligned burst: 16 strobes every 2 cycles, data 0..15, addresses in order
        obs.delete();
        addr_q.delete();
        issue(1, 24'h00ABC0, 8'h00, 1'b1, t0);
        chk("burst_count", 32'(obs.size()), 32'(16));
        for (int k = 0; k < obs.size() && k < 16; k++) begin
            chk("burst_cycle", 32'(obs[k].c - t0), 32'(2 * (k + 1) + X));
            chk("burst_data", 32'(obs[k].d), 32'(k));
        end
        chk("burst_addrs", 32'(addr_q.size()), 32'(16));
        for (int k = 0; k < addr_q.size() && k < 16; k++)
            chk("burst_addr", 32'(addr_q[k]), 32'(24'h00ABC0 + k));
        idle_cycles(1);

        // Write then back-to-back read of the same byte
        obs.delete();
        we_cnt = 0;
        issue(2, 24'h000200, 8'h5A, 1'b1, t0);
        chk("wr_count", 32'(obs.size()), 32'(1));
        if (obs.size() > 0) chk("wr_cycle", 32'(obs[0].c - t0), 32'(4));
        chk("we_low_cycles", 32'(we_cnt), 32'(2));
        chk("sram_holds", 32'(sram_arr[12'h200]), 32'(8'h5A));
        obs.delete();
        issue(0, 24'h000200, 8'h00, 1'b1, t0);
        chk("rbw_count", 32'(obs.size()), 32'(1));
        if (obs.size() > 0) begin
            chk("rbw_cycle", 32'(obs[0].c - t0), 32'(2 + X));
            chk("rbw_data", 32'(obs[0].d), 32'(8'h5A));
        end

        // Randomized traffic, often back-to-back, mem_en junk while busy
        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) a = 24'($urandom);
            else a = 24'(32'h100 + $urandom_range(0, 63));
            issue(kind, a, 8'($urandom), 1'b0, t0);
            n = int'($urandom_range(0, 2));
            if (n != 0) idle_cycles(n);
        end

        // Reset after the fifth burst beat
        idle_cycles(1);
        obs.delete();
        t0             = cyc;
        bus.mem_en     = 1'b1;
        bus.mem_wr     = 1'b0;
        bus.mem_rburst = 1'b1;
        bus.mem_addr   = 24'h0100C0;
        model_txn(1, 24'h0100C0, 8'h00, t0);
        @(negedge clk);
        bus.mem_en = 1'b0;
        while (cyc < t0 + 5 * L + X + 1) @(negedge clk);
        chk("pre_reset_beats", 32'(obs.size()), 32'(5));
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ce_n",  32'(sram_ce_n), 32'(1));
        chk("mid_rst_oe_n",  32'(sram_oe_n), 32'(1));
        chk("mid_rst_we_n",  32'(sram_we_n), 32'(1));
        chk("mid_rst_dq_oe", 32'(sram_dq_oe), 32'(0));
        chk("mid_rst_rdy",   32'(bus.mem_rdy), 32'(1));
        chk("mid_rst_load",  32'(bus.mem_rdata_load), 32'(0));
        chk("mid_rst_rdata", 32'(bus.mem_rdata), 32'(0));
        chk("mid_rst_addr",  32'(sram_addr), 32'(0));
        exp_load.delete();
        exp_data.delete();
        last_model = 8'h00;
        cur_rd     = 8'h00;
        busy_from  = 1;
        busy_to    = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs.delete();
        chk_en = 1'b1;
        idle_cycles(12);
        chk("post_reset_strobes", 32'(obs.size()), 32'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
